// File: rtl/dmem_map_pkg.sv
// Address map, status-word layout and decode helper shared by the data-memory
// responder and its bench.
package dmem_map_pkg;

  localparam logic [31:0] TIMER_ADDR   = 32'hFFFF_0000;
  localparam logic [31:0] CONSOLE_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] HALT_ADDR    = 32'hFFFF_0008;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic [2:0] {
    REG_RAM, REG_TIMER, REG_CONSOLE, REG_HALT, REG_NONE
  } reg_sel_e;

  // ram_aw is the RAM word-index width; byte-lane bits [1:0] never take part.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                           input int unsigned ram_aw);
    logic [31:0] hi;
    hi = addr >> (ram_aw + 2);
    if (hi == 32'd0)                           return REG_RAM;
    else if (addr[31:2] == TIMER_ADDR[31:2])   return REG_TIMER;
    else if (addr[31:2] == CONSOLE_ADDR[31:2]) return REG_CONSOLE;
    else if (addr[31:2] == HALT_ADDR[31:2])    return REG_HALT;
    else                                       return REG_NONE;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data-memory bus plus the console drain handshake and status flags.
interface dmem_responder_if;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2mem_data;
  logic [31:0] mem2proc_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic        bus_err;

  modport master (
    output proc2Dmem_command, proc2Dmem_addr, proc2mem_data, tx_ready,
    input  mem2proc_data, tx_valid, tx_data, halt, bus_err
  );

  modport slave (
    input  proc2Dmem_command, proc2Dmem_addr, proc2mem_data, tx_ready,
    output mem2proc_data, tx_valid, tx_data, halt, bus_err
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB wrap pointers; a push into a full FIFO is
// still taken when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok, push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign count   = wr_ptr_q - rd_ptr_q;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory bus responder: word RAM, cycle timer, console FIFO and halt flag
// behind one decode; loads are combinational, stores commit on the edge.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int RAM_AW = $clog2(DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e        sel;
  logic            is_load, is_store;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]     ram_q [DEPTH];
  logic            ram_we;

  logic [31:0]     timer_q, timer_d;
  logic            halt_q, halt_d, bus_err_q, bus_err_d, ovf_q, ovf_d;

  logic            f_push, f_full, f_empty, f_drop;
  logic [CW-1:0]   f_count;
  logic [7:0]      f_dout;
  logic [31:0]     status, rdata;

  assign sel      = decode_addr(bus.proc2Dmem_addr, RAM_AW);
  assign is_load  = (bus.proc2Dmem_command == BUS_LOAD);
  assign is_store = (bus.proc2Dmem_command == BUS_STORE);
  assign ram_idx  = bus.proc2Dmem_addr[RAM_AW+1:2];
  assign ram_we   = is_store && (sel == REG_RAM);
  assign f_push   = is_store && (sel == REG_CONSOLE);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .din   (bus.proc2mem_data[7:0]),
    .pop   (bus.tx_ready),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count),
    .drop  (f_drop)
  );

  // Status is read from pre-edge FIFO state, so it never sees this cycle's push/pop.
  always_comb begin
    status                    = '0;
    status[ST_EMPTY]          = f_empty;
    status[ST_FULL]           = f_full;
    status[ST_OVF]            = ovf_q;
    status[ST_CNT_LSB +: 4]   = 4'(f_count);
  end

  always_comb begin
    rdata = '0;
    if (is_load) begin
      case (sel)
        REG_RAM:     rdata = ram_q[ram_idx];
        REG_TIMER:   rdata = timer_q;
        REG_CONSOLE: rdata = status;
        REG_HALT:    rdata = {31'b0, halt_q};
        default:     rdata = '0;
      endcase
    end
  end

  always_comb begin
    timer_d   = timer_q + 32'd1;
    halt_d    = halt_q;
    bus_err_d = bus_err_q;
    ovf_d     = ovf_q | f_drop;
    if (is_store && sel == REG_TIMER) timer_d = bus.proc2mem_data;
    if (is_store && sel == REG_HALT)  halt_d  = 1'b1;
    if ((is_load || is_store) && sel == REG_NONE) bus_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= '0;
      halt_q    <= 1'b0;
      bus_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      halt_q    <= halt_d;
      bus_err_q <= bus_err_d;
      ovf_q     <= ovf_d;
    end
  end

  // RAM contents survive reset by design.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= bus.proc2mem_data;
  end

  assign bus.mem2proc_data = rdata;
  assign bus.tx_valid      = !f_empty;
  assign bus.tx_data       = f_dout;
  assign bus.halt          = halt_q;
  assign bus.bus_err       = bus_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: directed bus traffic pushes expected
// load data and console bytes; a negedge monitor pops and compares.
module tb_dmem_responder;
  import dmem_map_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(1024), .FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] v; bit ne; } exp_t;
  exp_t       load_q[$];
  logic [7:0] tx_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] d);
    bus.proc2Dmem_command = cmd;
    bus.proc2Dmem_addr    = a;
    bus.proc2mem_data     = d;
    @(posedge clk);
    #1;
    bus.proc2Dmem_command = BUS_NONE;
  endtask

  task automatic idle();
    drive(BUS_NONE, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(BUS_STORE, a, d);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp, input bit ne = 1'b0);
    exp_t e;
    e.v = exp;
    e.ne = ne;
    load_q.push_back(e);
    drive(BUS_LOAD, a, 32'h0);
  endtask

  // Monitor: compares on every live cycle, independent of the stimulus thread.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [7:0] b;
    if (!rst) begin
      if (bus.proc2Dmem_command == BUS_LOAD) begin
        if (load_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load got %h expected none", bus.mem2proc_data);
        end else begin
          e = load_q.pop_front();
          if (e.ne) begin
            checks++;
            if (bus.mem2proc_data === e.v) begin
              errors++;
              $display("FAIL load_distinct got %h expected not %h", bus.mem2proc_data, e.v);
            end
          end else chk("load_data", bus.mem2proc_data, e.v);
        end
      end else chk("idle_data_zero", bus.mem2proc_data, 32'h0);

      if (bus.tx_valid && bus.tx_ready) begin
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx got %h expected none", bus.tx_data);
        end else begin
          b = tx_q.pop_front();
          chk("tx_byte", {24'h0, bus.tx_data}, {24'h0, b});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.proc2Dmem_command = BUS_NONE;
    bus.proc2Dmem_addr    = '0;
    bus.proc2mem_data     = '0;
    bus.tx_ready          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem2proc", bus.mem2proc_data, 32'h0);
    chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    chk("rst_halt", {31'h0, bus.halt}, 32'h0);
    chk("rst_bus_err", {31'h0, bus.bus_err}, 32'h0);
    rst = 1'b0;

    // Timer: counts from 0, load and wrap.
    repeat (10) idle();
    load(TIMER_ADDR, 32'd10);
    store(TIMER_ADDR, 32'hFFFF_FFFE);
    idle();
    load(TIMER_ADDR, 32'hFFFF_FFFF);
    load(TIMER_ADDR, 32'h0);

    // RAM round trip; byte offset ignored; neighbour word is separate.
    store(32'h40, 32'hCAFE_F00D);
    load(32'h40, 32'hCAFE_F00D);
    load(32'h43, 32'hCAFE_F00D);
    load(32'h44, 32'hCAFE_F00D, 1'b1);

    // Console fill to full, then overflow.
    for (int i = 0; i < 8; i++) begin
      store(CONSOLE_ADDR, 32'h41 + i);
      tx_q.push_back(8'(8'h41 + i));
    end
    load(CONSOLE_ADDR, 32'h82);
    chk("tx_valid_full", {31'h0, bus.tx_valid}, 32'h1);
    chk("tx_head_full", {24'h0, bus.tx_data}, 32'h41);
    store(CONSOLE_ADDR, 32'h49);
    load(CONSOLE_ADDR, 32'h86);
    chk("tx_head_hold", {24'h0, bus.tx_data}, 32'h41);

    // Push while full with a pop in the same cycle, then drain.
    bus.tx_ready = 1'b1;
    store(CONSOLE_ADDR, 32'h5A);
    tx_q.push_back(8'h5A);
    load(CONSOLE_ADDR, 32'h86);
    repeat (10) idle();
    chk("tx_valid_drained", {31'h0, bus.tx_valid}, 32'h0);
    chk("tx_queue_drained", tx_q.size(), 32'h0);
    load(CONSOLE_ADDR, 32'h05);

    // Push into an empty FIFO while ready: byte appears next cycle.
    chk("tx_valid_empty_push", {31'h0, bus.tx_valid}, 32'h0);
    tx_q.push_back(8'h77);
    store(CONSOLE_ADDR, 32'h77);
    chk("tx_valid_after_push", {31'h0, bus.tx_valid}, 32'h1);
    chk("tx_data_after_push", {24'h0, bus.tx_data}, 32'h77);
    idle();
    chk("tx_valid_after_pop", {31'h0, bus.tx_valid}, 32'h0);

    // Halt and unmapped access.
    chk("halt_before", {31'h0, bus.halt}, 32'h0);
    store(HALT_ADDR, 32'h0);
    chk("halt_after", {31'h0, bus.halt}, 32'h1);
    load(HALT_ADDR, 32'h1);
    chk("bus_err_before", {31'h0, bus.bus_err}, 32'h0);
    load(32'h8000_0000, 32'h0);
    chk("bus_err_after", {31'h0, bus.bus_err}, 32'h1);
    store(32'h48, 32'h1234_5678);
    load(32'h48, 32'h1234_5678);

    // Asynchronous reset between edges while a byte is offered.
    bus.tx_ready = 1'b0;
    store(CONSOLE_ADDR, 32'h11);
    store(CONSOLE_ADDR, 32'h22);
    chk("tx_valid_pre_rst", {31'h0, bus.tx_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    chk("arst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    chk("arst_halt", {31'h0, bus.halt}, 32'h0);
    chk("arst_bus_err", {31'h0, bus.bus_err}, 32'h0);
    bus.proc2Dmem_command = BUS_LOAD;
    bus.proc2Dmem_addr    = TIMER_ADDR;
    #1;
    chk("arst_timer", bus.mem2proc_data, 32'h0);
    @(posedge clk);
    #1;
    bus.proc2Dmem_command = BUS_NONE;
    rst = 1'b0;
    load(32'h40, 32'hCAFE_F00D);
    load(CONSOLE_ADDR, 32'h01);

    idle();
    chk("load_queue_empty", load_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule
